// File: rtl/btn_enable_gen.sv
// Purpose : debounce a raw push-button into one-cycle enable pulses with optional auto-repeat.
// Latency : first pulse is high in the cycle after edge N+DEBOUNCE_CYCLES+2 (N = first edge sampling btn_in high).
// Backpressure: none; free-running, the downstream counter must accept every enable pulse.
//
// Ports:
//   clk           rising-edge system clock
//   rst           asynchronous active-low reset (0 = reset)
//   btn_in        raw button, asynchronous to clk, active-high
//   enable        one-cycle pulse per debounced press, plus repeat pulses while held
//   pressed       debounced button level
//   repeat_active high while the auto-repeat state is active
module btn_enable_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic enable,
    output logic pressed,
    output logic repeat_active
);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } state_t;

    localparam logic [15:0] DB_L  = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] RD_L  = 16'(REPEAT_DELAY);
    localparam logic [15:0] RP_L  = 16'(REPEAT_PERIOD);
    localparam logic [15:0] ONE_L = 16'd1;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        enable_q, enable_d;
    logic        pressed_q, pressed_d;
    logic        repeat_q, repeat_d;
    logic        btn_s;

    // Two-flop synchroniser; the FSM only ever looks at the second stage.
    assign sync1_d = btn_in;
    assign sync2_d = sync1_q;
    assign btn_s   = sync2_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        enable_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DB_PRESS;
                    timer_d = ONE_L;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (timer_q == DB_L) begin
                    state_d  = HELD;
                    enable_d = 1'b1;
                    timer_d  = ONE_L;
                end else begin
                    timer_d = timer_q + ONE_L;
                end
            end
            HELD: begin
                // Release is tested first so it beats a simultaneous timer match.
                if (!btn_s) begin
                    state_d = DB_RELEASE;
                    timer_d = ONE_L;
                end else if (REPEAT_EN && (timer_q == RD_L)) begin
                    state_d  = REPEAT;
                    enable_d = 1'b1;
                    timer_d  = ONE_L;
                end else if (timer_q != RD_L) begin
                    // Without auto-repeat the timer parks at REPEAT_DELAY instead of wrapping.
                    timer_d = timer_q + ONE_L;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_d = DB_RELEASE;
                    timer_d = ONE_L;
                end else if (timer_q == RP_L) begin
                    enable_d = 1'b1;
                    timer_d  = ONE_L;
                end else begin
                    timer_d = timer_q + ONE_L;
                end
            end
            DB_RELEASE: begin
                // A bounce back high returns to HELD with the repeat delay restarted.
                if (btn_s) begin
                    state_d = HELD;
                    timer_d = ONE_L;
                end else if (timer_q == DB_L) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + ONE_L;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Level outputs are decoded from the next state so they register alongside it.
    always_comb begin
        pressed_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DB_RELEASE);
        repeat_d  = (state_d == REPEAT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= IDLE;
            timer_q   <= '0;
            enable_q  <= 1'b0;
            pressed_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            enable_q  <= enable_d;
            pressed_q <= pressed_d;
            repeat_q  <= repeat_d;
        end
    end

    assign enable        = enable_q;
    assign pressed       = pressed_q;
    assign repeat_active = repeat_q;

endmodule

// File: tb/tb_btn_enable_gen.sv
// Purpose : directed, table-driven check of btn_enable_gen with and without auto-repeat.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_btn_enable_gen;

    logic clk;
    logic rst;
    logic btn_in;
    logic en_a, pr_a, rp_a;
    logic en_b, pr_b, rp_b;
    logic [3:0] cnt;
    logic cnt_clr;

    int total;
    int bad;

    typedef struct {
        logic btn;
        logic en_a;
        logic pr;
        logic rp_a;
        logic en_b;
    } vec_t;

    vec_t v_clean [24];
    vec_t v_rep   [72];

    btn_enable_gen #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8), .REPEAT_EN(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .enable(en_a), .pressed(pr_a), .repeat_active(rp_a)
    );

    btn_enable_gen #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8), .REPEAT_EN(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .enable(en_b), .pressed(pr_b), .repeat_active(rp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit counter driven by the enable pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         cnt <= 4'd0;
        else if (cnt_clr) cnt <= 4'd0;
        else if (en_a)    cnt <= cnt + 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        btn_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_table(input string tag, input vec_t v [], input int n);
        for (int k = 0; k < n; k++) begin
            btn_in = v[k].btn;
            tick();
            chk($sformatf("%s_en_a@%0d", tag, k), int'(en_a), int'(v[k].en_a));
            chk($sformatf("%s_pr_a@%0d", tag, k), int'(pr_a), int'(v[k].pr));
            chk($sformatf("%s_rp_a@%0d", tag, k), int'(rp_a), int'(v[k].rp_a));
            chk($sformatf("%s_en_b@%0d", tag, k), int'(en_b), int'(v[k].en_b));
            chk($sformatf("%s_pr_b@%0d", tag, k), int'(pr_b), int'(v[k].pr));
            chk($sformatf("%s_rp_b@%0d", tag, k), int'(rp_b), 0);
        end
    endtask

    // Clean press of 10 cycles with a 0,1,0 glitch on release.
    task automatic press_glitch();
        btn_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        btn_in = 1'b0; tick();
        btn_in = 1'b1; tick();
        btn_in = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        btn_in  = 1'b0;
        cnt_clr = 1'b0;

        // Expected edge numbers below are hand-derived: sync (2) + debounce (4) = pulse after edge 6.
        for (int k = 0; k < 24; k++) begin
            v_clean[k].btn  = (k < 12);
            v_clean[k].en_a = (k == 6);
            v_clean[k].pr   = (k >= 6) && (k < 18);
            v_clean[k].rp_a = 1'b0;
            v_clean[k].en_b = (k == 6);
        end
        for (int k = 0; k < 72; k++) begin
            v_rep[k].btn  = (k < 60);
            v_rep[k].en_a = (k == 6) || (k == 22) || (k == 30) || (k == 38) || (k == 46) || (k == 54);
            v_rep[k].pr   = (k >= 6) && (k < 66);
            v_rep[k].rp_a = (k >= 22) && (k < 62);
            v_rep[k].en_b = (k == 6);
        end

        // Reset state.
        for (int i = 0; i < 3; i++) tick();
        chk("rst_en_a", int'(en_a), 0);
        chk("rst_pr_a", int'(pr_a), 0);
        chk("rst_rp_a", int'(rp_a), 0);
        chk("rst_cnt",  int'(cnt),  0);
        rst = 1'b1;
        idle(5);
        chk("idle_pr_a", int'(pr_a), 0);

        // Clean press and release.
        run_table("clean", v_clean, 24);
        idle(10);

        // Bounce 1,1,1,0 x10: never enough stable cycles.
        for (int r = 0; r < 10; r++) begin
            for (int p = 0; p < 4; p++) begin
                btn_in = (p != 3);
                tick();
                chk($sformatf("bounce_en_a@%0d", r * 4 + p), int'(en_a), 0);
                chk($sformatf("bounce_pr_a@%0d", r * 4 + p), int'(pr_a), 0);
                chk($sformatf("bounce_en_b@%0d", r * 4 + p), int'(en_b), 0);
            end
        end
        idle(10);
        chk("bounce_pr_after", int'(pr_a), 0);

        // Auto-repeat (dut_a) and single-pulse (dut_b) on the same stimulus.
        run_table("rep", v_rep, 72);
        idle(10);

        // Asynchronous reset mid-REPEAT with the button still held.
        btn_in = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("pre_rst_rp_a", int'(rp_a), 1);
        chk("pre_rst_pr_b", int'(pr_b), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_en_a", int'(en_a), 0);
        chk("arst_pr_a", int'(pr_a), 0);
        chk("arst_rp_a", int'(rp_a), 0);
        chk("arst_pr_b", int'(pr_b), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("rerel_en_a@%0d", k), int'(en_a), int'(k == 6));
            chk($sformatf("rerel_pr_a@%0d", k), int'(pr_a), int'(k >= 6));
            chk($sformatf("rerel_en_b@%0d", k), int'(en_b), int'(k == 6));
        end
        idle(15);
        chk("rerel_pr_off", int'(pr_a), 0);

        // Integration with the downstream counter.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("cnt_clr", int'(cnt), 0);
        for (int i = 0; i < 5; i++) begin
            press_glitch();
            chk($sformatf("cnt5_press%0d", i), int'(cnt), i + 1);
        end
        chk("cnt_five", int'(cnt), 5);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) press_glitch();
        chk("cnt_wrap", int'(cnt), 1);
        chk("cnt_wrap_pr", int'(pr_a), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
